disparity_select: RTL and testbench
===================================

# disparity_select

Sequential winner-take-all stage that consumes the stream of per-group minima (window sum plus its disparity) from the 4-way window-sum comparator tree and reduces GROUPS consecutive groups to one final disparity per pixel. It also tracks the second-best window sum and flags the result as unique when the margin meets a threshold. It sits between the comparator tree and the depth-map write path, with valid/ready handshakes on both sides and a one-entry result buffer.

## Interface
- WS_W, 14, window-sum width
- DISP_W, 6, disparity width
- GROUPS, 16, comparator-tree results per pixel (≥1)
- UNIQ_THRESH, 8, minimum (second − best) margin for a unique result
- clock  in  1  single clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  in_ws/in_disp carry a group result
- in_ready  out  1  block accepts the beat this cycle
- in_ws  in  WS_W  group-minimum window sum
- in_disp  in  DISP_W  disparity of in_ws
- out_valid  out  1  result register holds an unconsumed pixel result
- out_ready  in  1  downstream accepts the result
- out_disparity  out  DISP_W  winning disparity
- out_window_sum  out  WS_W  winning window sum
- out_unique  out  1  (second − best) ≥ UNIQ_THRESH

## Operation
- Beat accepted when in_valid && in_ready. Result consumed when out_valid && out_ready.
- Internal: group counter grp (0..GROUPS−1), accumulators best_ws, best_disp, second_ws.
- grp==0 beat: best_ws←in_ws, best_disp←in_disp, second_ws←all ones.
- grp>0 beat: if in_ws < best_ws: second_ws←best_ws, best_ws←in_ws, best_disp←in_disp. Else if in_ws < second_ws: second_ws←in_ws. Else no change.
- Strict compares: on equal sums the earlier beat keeps the win, and the tied sum becomes second_ws, giving margin 0.
- Last beat (grp==GROUPS−1): the candidate result is computed using the same update rule including this beat. It is loaded into the output register with out_valid←1. grp wraps to 0. Accumulators are don't-care until the next grp==0 load.
- Margin = second_ws − best_ws, unsigned WS_W bits, no overflow since second ≥ best. With GROUPS==1, second is all ones.
- in_ready = !(out_valid && !out_ready && grp==GROUPS−1). Non-last beats are always accepted, so accumulation of the next pixel overlaps a stalled result. Only the last beat waits for the buffer.
- Last beat accepted in the same cycle the old result drains: the output register reloads and out_valid stays 1.
- Result drained with no new last beat: out_valid←0.
- in_valid low: no state change. Gaps between beats are allowed anywhere.
- Outputs are held stable while out_valid && !out_ready.
- Reset asserted mid-pixel discards the partial accumulation and any held result; the first beat after release is treated as grp==0.

## Timing
- Reset values: out_valid=0, out_disparity=0, out_window_sum=0, out_unique=0, grp=0. in_ready=1 while reset is deasserted and idle.
- Latency: out_valid rises on the first edge after the last beat is accepted (1 cycle).
- Throughput: one beat per cycle sustained when out_ready=1. Back-to-back pixels need no bubble.
- in_ready is combinational from out_valid, out_ready and grp. It has no combinational path from in_valid.
- out_* outputs are driven directly from registers.

## Test plan
- GROUPS=4, UNIQ_THRESH=8, out_ready=1. Beats (ws,disp) = (100,0),(40,1),(60,2),(90,3) → one cycle after the 4th beat: out_valid=1, disparity=1, window_sum=40, unique=1 (margin 20).
- Tie case. Beats (50,0),(50,1),(70,2),(80,3) → disparity=0, window_sum=50, unique=0 (margin 0).
- Near-tie case. Beats (30,0),(35,1),(99,2),(99,3) → disparity=0, unique=0 (margin 5). Repeat with (38,1) in place of (35,1) → unique=1 (margin 8, boundary).
- Backpressure. out_ready=0 after pixel A completes. Stream pixel B: 3 beats are accepted, and in_ready=0 on B's 4th beat. Pixel A's outputs stay stable. Raise out_ready → A consumed and B's last beat accepted in the same cycle. B appears on the next cycle with no beat lost.
- Random in_valid gaps with out_ready=1 across 10 pixels. Results must match a reference min/second-min model, and the out_valid count must equal 10.
- Reset after 2 beats of a pixel while a result is held → out_valid=0. The next 4 beats form a complete, correct pixel.

Source files
------------

// File: rtl/disparity_select.sv
// Winner-take-all over GROUPS comparator-tree minima per pixel, tracking second-best for a uniqueness flag.
// One-entry result buffer; only the last beat of a pixel stalls on a full, unconsumed buffer.
module disparity_select #(
   parameter int WS_W        = 14,
   parameter int DISP_W      = 6,
   parameter int GROUPS      = 16,
   parameter int UNIQ_THRESH = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WS_W-1:0]   in_ws,
   input  logic [DISP_W-1:0] in_disp,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DISP_W-1:0] out_disparity,
   output logic [WS_W-1:0]   out_window_sum,
   output logic              out_unique
);

   localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;

   logic [GW-1:0]     grp;
   logic [WS_W-1:0]   best_ws;
   logic [DISP_W-1:0] best_disp;
   logic [WS_W-1:0]   second_ws;

   logic              last_beat;
   logic              accept;
   logic [WS_W-1:0]   nxt_best_ws;
   logic [DISP_W-1:0] nxt_best_disp;
   logic [WS_W-1:0]   nxt_second_ws;
   logic [WS_W-1:0]   margin;

   assign last_beat = (grp == GW'(GROUPS - 1));
   assign in_ready  = !(out_valid && !out_ready && last_beat);
   assign accept    = in_valid && in_ready;

   // Strict less-than keeps the earlier beat on ties; the tied sum drops into second place.
   always_comb begin
      nxt_best_ws   = best_ws;
      nxt_best_disp = best_disp;
      nxt_second_ws = second_ws;
      if (grp == '0) begin
         nxt_best_ws   = in_ws;
         nxt_best_disp = in_disp;
         nxt_second_ws = '1;
      end else if (in_ws < best_ws) begin
         nxt_second_ws = best_ws;
         nxt_best_ws   = in_ws;
         nxt_best_disp = in_disp;
      end else if (in_ws < second_ws) begin
         nxt_second_ws = in_ws;
      end
   end

   assign margin = nxt_second_ws - nxt_best_ws;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         grp            <= '0;
         best_ws        <= '0;
         best_disp      <= '0;
         second_ws      <= '0;
         out_valid      <= 1'b0;
         out_disparity  <= '0;
         out_window_sum <= '0;
         out_unique     <= 1'b0;
      end else begin
         if (accept) begin
            best_ws   <= nxt_best_ws;
            best_disp <= nxt_best_disp;
            second_ws <= nxt_second_ws;
            grp       <= last_beat ? '0 : grp + GW'(1);
         end
         if (accept && last_beat) begin
            out_valid      <= 1'b1;
            out_disparity  <= nxt_best_disp;
            out_window_sum <= nxt_best_ws;
            out_unique     <= (margin >= WS_W'(UNIQ_THRESH));
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_disparity_select.sv
// Directed and randomized checks of disparity_select (GROUPS=4) against a min/second-min model.
module tb_disparity_select;

   localparam int WS_W   = 14;
   localparam int DISP_W = 6;
   localparam int GROUPS = 4;
   localparam int THRESH = 8;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [WS_W-1:0]   in_ws = '0;
   logic [DISP_W-1:0] in_disp = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [DISP_W-1:0] out_disparity;
   logic [WS_W-1:0]   out_window_sum;
   logic              out_unique;

   int vectors = 0;
   int miscompares = 0;
   int n_out = 0;
   int px_ws[GROUPS];
   int px_disp[GROUPS];
   int exp_disp, exp_ws, exp_uniq;

   disparity_select #(.WS_W(WS_W), .DISP_W(DISP_W), .GROUPS(GROUPS), .UNIQ_THRESH(THRESH)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_ws(in_ws), .in_disp(in_disp),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_disparity(out_disparity), .out_window_sum(out_window_sum), .out_unique(out_unique)
   );

   always #5 clock = ~clock;

   always @(posedge clock) if (!reset && out_valid && out_ready) n_out <= n_out + 1;

   initial begin
      #500000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Winner is the earliest minimum; second is the smallest of all other beats.
   task automatic model();
      int bi = 0;
      int sec = (1 << WS_W) - 1;
      for (int i = 1; i < GROUPS; i++) if (px_ws[i] < px_ws[bi]) bi = i;
      for (int j = 0; j < GROUPS; j++) if (j != bi && px_ws[j] < sec) sec = px_ws[j];
      exp_disp = px_disp[bi];
      exp_ws   = px_ws[bi];
      exp_uniq = ((sec - px_ws[bi]) >= THRESH) ? 1 : 0;
   endtask

   task automatic send_beat(input int ws, input int d);
      int waited = 0;
      in_valid = 1'b1;
      in_ws    = WS_W'(ws);
      in_disp  = DISP_W'(d);
      while (!in_ready && waited < 100) begin
         @(negedge clock);
         waited++;
      end
      check("in_ready_wait", {31'd0, in_ready}, 32'd1);
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   task automatic run_pixel(input int w0, input int w1, input int w2, input int w3,
                            input int d0, input int d1, input int d2, input int d3,
                            input int gap_max);
      px_ws[0] = w0; px_ws[1] = w1; px_ws[2] = w2; px_ws[3] = w3;
      px_disp[0] = d0; px_disp[1] = d1; px_disp[2] = d2; px_disp[3] = d3;
      model();
      for (int i = 0; i < GROUPS; i++) begin
         repeat ($urandom_range(0, gap_max)) @(negedge clock);
         send_beat(px_ws[i], px_disp[i]);
      end
   endtask

   task automatic check_result(input string tag, input int d, input int ws, input int u);
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_disp"}, 32'(out_disparity), 32'(d));
      check({tag, "_ws"}, 32'(out_window_sum), 32'(ws));
      check({tag, "_uniq"}, {31'd0, out_unique}, 32'(u));
   endtask

   initial begin
      int start_cnt;
      repeat (2) @(negedge clock);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_disp", 32'(out_disparity), 32'd0);
      check("rst_ws", 32'(out_window_sum), 32'd0);
      check("rst_uniq", {31'd0, out_unique}, 32'd0);
      reset = 1'b0;
      @(negedge clock);
      check("idle_in_ready", {31'd0, in_ready}, 32'd1);
      check("idle_valid", {31'd0, out_valid}, 32'd0);

      // Basic: one cycle after the 4th beat the result is present
      run_pixel(100, 40, 60, 90, 0, 1, 2, 3, 0);
      check_result("basic", 1, 40, 1);
      run_pixel(50, 50, 70, 80, 0, 1, 2, 3, 0);
      check_result("tie", 0, 50, 0);
      run_pixel(30, 35, 99, 99, 0, 1, 2, 3, 0);
      check_result("near5", 0, 30, 0);
      run_pixel(30, 38, 99, 99, 0, 1, 2, 3, 0);
      check_result("near8", 0, 30, 1);
      @(negedge clock);
      check("drained", {31'd0, out_valid}, 32'd0);

      // Backpressure: A held while B accumulates; B's last beat waits for the drain
      out_ready = 1'b0;
      run_pixel(20, 80, 30, 90, 5, 6, 7, 8, 0);
      check_result("bpA", 5, 20, 1);
      send_beat(200, 1);
      send_beat(150, 2);
      send_beat(300, 3);
      check_result("bpA_held", 5, 20, 1);
      in_valid = 1'b1; in_ws = WS_W'(10); in_disp = DISP_W'(4);
      #1 check("bp_stall", {31'd0, in_ready}, 32'd0);
      @(negedge clock);
      check("bp_stall2", {31'd0, in_ready}, 32'd0);
      check_result("bpA_held2", 5, 20, 1);
      out_ready = 1'b1;
      #1 check("bp_release", {31'd0, in_ready}, 32'd1);
      @(negedge clock);
      in_valid = 1'b0;
      check_result("bpB", 4, 10, 1);
      @(negedge clock);
      check("bpB_drained", {31'd0, out_valid}, 32'd0);

      // Reset mid-pixel with a held result
      out_ready = 1'b0;
      run_pixel(60, 70, 80, 90, 1, 2, 3, 4, 0);
      check_result("rsth", 1, 60, 1);
      send_beat(5, 9);
      send_beat(6, 10);
      reset = 1'b1;
      #1 check("rst2_valid", {31'd0, out_valid}, 32'd0);
      check("rst2_disp", 32'(out_disparity), 32'd0);
      check("rst2_ws", 32'(out_window_sum), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      out_ready = 1'b1;
      run_pixel(50, 45, 47, 100, 11, 12, 13, 14, 0);
      check_result("post_rst", 12, 45, 0);
      @(negedge clock);

      // Randomized pixels with gaps
      start_cnt = n_out;
      for (int p = 0; p < 10; p++) begin
         run_pixel($urandom_range(0, 120), $urandom_range(0, 120), $urandom_range(0, 120),
                   $urandom_range(0, 120), $urandom_range(0, 63), $urandom_range(0, 63),
                   $urandom_range(0, 63), $urandom_range(0, 63), 2);
         check_result("rand", exp_disp, exp_ws, exp_uniq);
      end
      @(negedge clock);
      check("rand_count", 32'(n_out - start_cnt), 32'd10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
